count_seq_checker: RTL and testbench

- Receive-side monitor for the modulo-N counter stream produced by the team's free-running counters, e.g. the 0..40 mod-41 counter.
- Samples a W-bit count bus and locks onto the expected wrap sequence.
- Flags skips, repeats and out-of-range values.
- Keeps saturating error and wrapping wrap statistics for bring-up and self-check benches.

---
 rtl/count_seq_checker_if.sv | 38 +++
 rtl/count_seq_checker.sv | 190 +++++++++++++++++++
 tb/tb_count_seq_checker.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/count_seq_checker_if.sv
// Bundle between a modulo-N count source and its sequence checker:
// the sampled count stream plus the checker's status and statistics.
interface count_seq_checker_if #(
   parameter int W = 6
);
   logic [W-1:0] cnt_in;
   logic         cnt_vld;
   logic         locked;
   logic [W-1:0] expected;
   logic         err_pulse;
   logic         wrap_pulse;
   logic [7:0]   err_count;
   logic [7:0]   wrap_count;

   // Count source: drives the stream, observes checker status.
   modport master (
      output cnt_in,
      output cnt_vld,
      input  locked,
      input  expected,
      input  err_pulse,
      input  wrap_pulse,
      input  err_count,
      input  wrap_count
   );

   // Checker: consumes the stream, publishes status.
   modport slave (
      input  cnt_in,
      input  cnt_vld,
      output locked,
      output expected,
      output err_pulse,
      output wrap_pulse,
      output err_count,
      output wrap_count
   );
endinterface : count_seq_checker_if

// File: rtl/count_seq_checker.sv
// Receive-side monitor for a free-running modulo-MOD counter stream.
// Hunts for a seed value, verifies LOCK_RUN consecutive in-sequence samples,
// then tracks the sequence, flagging skips/repeats while locked and
// out-of-range values in any state. Keeps a saturating error count and a
// wrapping count of in-sequence MOD-1 -> 0 wraps seen while locked.
module count_seq_checker #(
   parameter int W        = 6,
   parameter int MOD      = 41,
   parameter int LOCK_RUN = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   count_seq_checker_if.slave   bus
);

   // Run counter only needs to reach LOCK_RUN.
   localparam int RW = $clog2(LOCK_RUN + 1);

   // Largest legal count value; the successor of this one is zero.
   localparam logic [W-1:0] MAX_VAL  = W'(MOD - 1);
   // Modulus widened by one bit so MOD == 2^W is still representable.
   localparam logic [W:0]   MOD_EXT  = (W + 1)'(MOD);
   localparam logic [RW-1:0] RUN_LOCK = RW'(LOCK_RUN);
   localparam logic [RW-1:0] RUN_ONE  = RW'(1);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // Successor of a count value in the modulo-MOD sequence.
   function automatic logic [W-1:0] f_nxt(input logic [W-1:0] x);
      logic [W-1:0] y;
      if (x == MAX_VAL) begin
         y = {W{1'b0}};
      end else begin
         y = x + {{(W-1){1'b0}}, 1'b1};
      end
      return y;
   endfunction

   // Eight-bit increment that sticks at all-ones.
   function automatic logic [7:0] f_sat_inc8(input logic [7:0] x);
      logic [7:0] y;
      if (x == 8'hFF) begin
         y = 8'hFF;
      end else begin
         y = x + 8'd1;
      end
      return y;
   endfunction

   // Registered state and outputs.
   state_t        r_state;
   logic [RW-1:0] r_run;
   logic [W-1:0]  r_expected;
   logic          r_locked;
   logic          r_err_pulse;
   logic          r_wrap_pulse;
   logic [7:0]    r_err_count;
   logic [7:0]    r_wrap_count;

   // Next-state values.
   state_t        w_state_nxt;
   logic [RW-1:0] w_run_nxt;
   logic [W-1:0]  w_expected_nxt;
   logic          w_locked_nxt;
   logic          w_err_pulse_nxt;
   logic          w_wrap_pulse_nxt;
   logic [7:0]    w_err_count_nxt;
   logic [7:0]    w_wrap_count_nxt;

   // Sample classification.
   logic          w_out_of_range;
   logic          w_match;
   logic [W-1:0]  w_seed_exp;
   logic [RW-1:0] w_run_inc;

   assign w_out_of_range = ({1'b0, bus.cnt_in} >= MOD_EXT);
   assign w_match        = (bus.cnt_in == r_expected);
   assign w_seed_exp     = f_nxt(bus.cnt_in);
   assign w_run_inc      = r_run + RUN_ONE;

   // Next-state and output decode; idle cycles hold everything except pulses.
   always_comb begin
      w_state_nxt      = r_state;
      w_run_nxt        = r_run;
      w_expected_nxt   = r_expected;
      w_locked_nxt     = r_locked;
      w_err_pulse_nxt  = 1'b0;
      w_wrap_pulse_nxt = 1'b0;
      w_err_count_nxt  = r_err_count;
      w_wrap_count_nxt = r_wrap_count;

      if (bus.cnt_vld) begin
         if (w_out_of_range) begin
            // Illegal value in any state: drop back to hunting.
            w_err_pulse_nxt = 1'b1;
            w_err_count_nxt = f_sat_inc8(r_err_count);
            w_state_nxt     = ST_HUNT;
            w_run_nxt       = {RW{1'b0}};
            w_locked_nxt    = 1'b0;
         end else begin
            case (r_state)
               ST_HUNT: begin
                  // Any legal value seeds the sequence; nothing to compare yet.
                  w_expected_nxt = w_seed_exp;
                  w_run_nxt      = RUN_ONE;
                  w_state_nxt    = ST_VERIFY;
               end
               ST_VERIFY: begin
                  w_expected_nxt = w_seed_exp;
                  if (w_match) begin
                     w_run_nxt = w_run_inc;
                     if (w_run_inc == RUN_LOCK) begin
                        w_state_nxt  = ST_LOCKED;
                        w_locked_nxt = 1'b1;
                     end else begin
                        w_state_nxt = ST_VERIFY;
                     end
                  end else begin
                     // Not yet trusted, so a break just restarts the run.
                     w_run_nxt   = RUN_ONE;
                     w_state_nxt = ST_VERIFY;
                  end
               end
               ST_LOCKED: begin
                  w_expected_nxt = w_seed_exp;
                  if (w_match) begin
                     // An in-sequence zero is only reachable from MAX_VAL.
                     if (bus.cnt_in == {W{1'b0}}) begin
                        w_wrap_pulse_nxt = 1'b1;
                        w_wrap_count_nxt = r_wrap_count + 8'd1;
                     end else begin
                        w_wrap_pulse_nxt = 1'b0;
                     end
                  end else begin
                     // Skip or repeat: flag it and reseed from this value.
                     w_err_pulse_nxt = 1'b1;
                     w_err_count_nxt = f_sat_inc8(r_err_count);
                     w_locked_nxt    = 1'b0;
                     w_run_nxt       = RUN_ONE;
                     w_state_nxt     = ST_VERIFY;
                  end
               end
               default: begin
                  // Unreachable encoding: recover by hunting.
                  w_state_nxt  = ST_HUNT;
                  w_run_nxt    = {RW{1'b0}};
                  w_locked_nxt = 1'b0;
               end
            endcase
         end
      end else begin
         w_state_nxt = r_state;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= ST_HUNT;
         r_run        <= {RW{1'b0}};
         r_expected   <= {W{1'b0}};
         r_locked     <= 1'b0;
         r_err_pulse  <= 1'b0;
         r_wrap_pulse <= 1'b0;
         r_err_count  <= 8'd0;
         r_wrap_count <= 8'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_run        <= w_run_nxt;
         r_expected   <= w_expected_nxt;
         r_locked     <= w_locked_nxt;
         r_err_pulse  <= w_err_pulse_nxt;
         r_wrap_pulse <= w_wrap_pulse_nxt;
         r_err_count  <= w_err_count_nxt;
         r_wrap_count <= w_wrap_count_nxt;
      end
   end

   assign bus.locked     = r_locked;
   assign bus.expected   = r_expected;
   assign bus.err_pulse  = r_err_pulse;
   assign bus.wrap_pulse = r_wrap_pulse;
   assign bus.err_count  = r_err_count;
   assign bus.wrap_count = r_wrap_count;

endmodule : count_seq_checker

// File: tb/tb_count_seq_checker.sv
// Self-checking bench for count_seq_checker: directed scenarios followed by
// a randomized phase, all compared against a behavioural model each cycle.
module tb_count_seq_checker;

   localparam int W        = 6;
   localparam int MOD      = 41;
   localparam int LOCK_RUN = 4;
   localparam int MAXV     = (1 << W) - 1;

   logic clk;
   logic rst;

   count_seq_checker_if #(.W(W)) bus ();

   count_seq_checker #(
      .W        (W),
      .MOD      (MOD),
      .LOCK_RUN (LOCK_RUN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Behavioural model: length of the current in-sequence run (0 = hunting).
   int m_run       = 0;
   bit m_locked    = 0;
   int m_exp       = 0;
   bit m_exp_known = 1;
   int m_err       = 0;
   int m_wrap      = 0;
   bit m_errp      = 0;
   bit m_wrapp     = 0;

   // Source counter value.
   int src = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic model_update(input bit rst_v, input bit vld, input int val);
      if (!rst_v) begin
         m_run = 0; m_locked = 0; m_exp = 0; m_exp_known = 1;
         m_err = 0; m_wrap = 0; m_errp = 0; m_wrapp = 0;
      end else begin
         m_errp  = 0;
         m_wrapp = 0;
         if (vld) begin
            if (val >= MOD) begin
               m_errp = 1;
               if (m_err < 255) m_err++;
               m_run = 0; m_locked = 0; m_exp_known = 0;
            end else if (m_run == 0) begin
               m_run = 1; m_exp = (val + 1) % MOD; m_exp_known = 1;
            end else if (val == m_exp) begin
               m_exp = (val + 1) % MOD;
               if (m_locked) begin
                  if (val == 0) begin
                     m_wrapp = 1;
                     m_wrap  = (m_wrap + 1) % 256;
                  end
               end else begin
                  m_run++;
                  if (m_run >= LOCK_RUN) m_locked = 1;
               end
            end else begin
               if (m_locked) begin
                  m_errp = 1;
                  if (m_err < 255) m_err++;
               end
               m_locked = 0; m_run = 1; m_exp = (val + 1) % MOD;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("locked", bus.locked, m_locked);
      if (m_exp_known) chk("expected", bus.expected, m_exp);
      chk("err_pulse", bus.err_pulse, m_errp);
      chk("wrap_pulse", bus.wrap_pulse, m_wrapp);
      chk("err_count", bus.err_count, m_err);
      chk("wrap_count", bus.wrap_count, m_wrap);
   endtask

   // One clock: drive inputs, take the edge, advance the model, check #1 later.
   task automatic step(input bit rst_v, input bit vld, input int val);
      rst         = rst_v;
      bus.cnt_vld = vld;
      bus.cnt_in  = val[W-1:0];
      @(posedge clk);
      model_update(rst_v, vld, val);
      #1;
      check_all();
   endtask

   // n valid samples straight from the source counter.
   task automatic run_seq(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b1, src);
         src = (src + 1) % MOD;
      end
   endtask

   initial begin
      int r;
      int v;
      rst         = 1'b0;
      bus.cnt_vld = 1'b0;
      bus.cnt_in  = '0;

      // Reset for three cycles.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5);
      chk("rst_locked", bus.locked, 0);
      chk("rst_expected", bus.expected, 0);
      chk("rst_err_count", bus.err_count, 0);

      // Lock and first wrap.
      src = 0;
      for (int i = 0; i < LOCK_RUN; i++) begin
         run_seq(1);
         chk("lock_progress", bus.locked, (i == LOCK_RUN - 1) ? 1 : 0);
         chk("lock_expected", bus.expected, i + 1);
      end
      while (src != 0) run_seq(1);
      run_seq(1);
      chk("first_wrap_pulse", bus.wrap_pulse, 1);
      chk("first_wrap_count", bus.wrap_count, 1);
      run_seq(1);
      chk("wrap_pulse_drop", bus.wrap_pulse, 0);
      chk("lock_err_count", bus.err_count, 0);

      // Long run: 300 further full periods.
      run_seq(300 * MOD);
      chk("long_wrap_count", bus.wrap_count, (1 + 300) % 256);
      chk("long_err_count", bus.err_count, 0);

      // Skip while locked: 20 where 17 is expected.
      while (src != 17) run_seq(1);
      step(1'b1, 1'b1, 20);
      chk("skip_err_pulse", bus.err_pulse, 1);
      chk("skip_err_count", bus.err_count, 1);
      chk("skip_locked", bus.locked, 0);
      chk("skip_expected", bus.expected, 21);
      src = 21;
      run_seq(2);
      chk("skip_relock_early", bus.locked, 0);
      run_seq(1);
      chk("skip_relock", bus.locked, 1);

      // Out-of-range value while locked.
      step(1'b1, 1'b1, 45);
      chk("oor_err_pulse", bus.err_pulse, 1);
      chk("oor_err_count", bus.err_count, 2);
      chk("oor_locked", bus.locked, 0);
      run_seq(LOCK_RUN - 1);
      chk("oor_relock_early", bus.locked, 0);
      run_seq(1);
      chk("oor_relock", bus.locked, 1);

      // Strobe gap with the source still running.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, src);
         src = (src + 1) % MOD;
         chk("gap_hold_locked", bus.locked, 1);
      end
      run_seq(1);
      chk("gap_err_pulse", bus.err_pulse, 1);
      chk("gap_err_count", bus.err_count, 3);
      run_seq(LOCK_RUN - 1);
      chk("gap_relock", bus.locked, 1);

      // Strobe gap with the source paused.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, src);
      run_seq(1);
      chk("pause_no_err", bus.err_pulse, 0);
      chk("pause_locked", bus.locked, 1);

      // Randomized mix of samples, gaps, skips, repeats and illegal values.
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 60) begin
            run_seq(1);
         end else if (r < 70) begin
            step(1'b1, 1'b0, $urandom_range(0, MAXV));
            src = (src + 1) % MOD;
         end else if (r < 80) begin
            step(1'b1, 1'b0, $urandom_range(0, MAXV));
         end else if (r < 88) begin
            v = $urandom_range(0, MOD - 1);
            step(1'b1, 1'b1, v);
            src = (v + 1) % MOD;
         end else if (r < 94) begin
            v = (src + MOD - 1) % MOD;
            step(1'b1, 1'b1, v);
         end else begin
            step(1'b1, 1'b1, $urandom_range(MOD, MAXV));
         end
      end

      // Reset mid-lock with err_count at 7.
      step(1'b0, 1'b1, src);
      run_seq(LOCK_RUN);
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 1'b1, $urandom_range(MOD, MAXV));
         run_seq(LOCK_RUN);
      end
      chk("pre_rst_err_count", bus.err_count, 7);
      chk("pre_rst_locked", bus.locked, 1);
      step(1'b0, 1'b1, src);
      chk("midrst_locked", bus.locked, 0);
      chk("midrst_expected", bus.expected, 0);
      chk("midrst_err_pulse", bus.err_pulse, 0);
      chk("midrst_wrap_pulse", bus.wrap_pulse, 0);
      chk("midrst_err_count", bus.err_count, 0);
      chk("midrst_wrap_count", bus.wrap_count, 0);

      // Saturation: 260 errors, then a few more.
      for (int i = 0; i < 260; i++) step(1'b1, 1'b1, $urandom_range(MOD, MAXV));
      chk("sat_err_count", bus.err_count, 255);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, $urandom_range(MOD, MAXV));
      chk("sat_hold", bus.err_count, 255);
      chk("sat_err_pulse", bus.err_pulse, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_count_seq_checker
